// File: rtl/wadd_pkg.sv
// rtl/wadd_pkg.sv - shared constants and FSM type for the sequential wide adder
package wadd_pkg;

  localparam int WORD_W        = 64;
  localparam int MAX_WORDS_DEF = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/cla64.sv
// rtl/cla64.sv - 64-bit carry-lookahead adder, 4-bit lookahead groups chained by group generate/propagate
module cla64 (
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic        i_cin,
  output logic [63:0] o_sum,
  output logic        o_cout
);

  logic [63:0] w_g;
  logic [63:0] w_p;
  logic [64:0] w_c;
  logic        w_gg;
  logic        w_gp;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    w_c    = '0;
    w_gg   = 1'b0;
    w_gp   = 1'b0;
    w_c[0] = i_cin;
    for (int k = 0; k < 16; k++) begin
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_gg = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
           | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
           | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_gp = &w_p[4*k +: 4];
      w_c[4*k+4] = w_gg | (w_gp & w_c[4*k]);
    end
  end

  assign o_sum  = w_p ^ w_c[63:0];
  assign o_cout = w_c[64];

endmodule

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - word-serial multi-word add/subtract, LS word first, one-cycle latency
module wide_add_seq
  import wadd_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_op,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_carry,
  output logic              out_ovf,
  output logic              out_zero,
  output logic              out_len_err
);

  localparam int CNT_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_carry;
  logic              r_op;
  logic              r_zero_acc;

  logic              w_accept;
  logic              w_first;
  logic              w_op;
  logic              w_cin;
  logic              w_end;
  logic [WORD_W-1:0] w_b;
  logic [WORD_W-1:0] w_sum;
  logic              w_cout;
  logic              w_c63;
  logic              w_zero_all;

  assign in_ready = !out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_first     = (r_state == ST_IDLE);
    w_op        = w_first ? in_op : r_op;
    w_cin       = w_first ? in_op : r_carry;
    w_end       = in_last | (r_cnt == CNT_W'(MAX_WORDS - 1));
    if (w_accept) begin
      w_state_nxt = w_end ? ST_IDLE : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_b = (w_op == OP_SUB) ? ~in_b : in_b;

  cla64 u_cla64 (
    .i_a    (in_a),
    .i_b    (w_b),
    .i_cin  (w_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Carry into the top bit is recovered from the top-bit sum and operands.
  assign w_c63      = w_sum[WORD_W-1] ^ in_a[WORD_W-1] ^ w_b[WORD_W-1];
  assign w_zero_all = (w_first ? 1'b1 : r_zero_acc) & (w_sum == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_op       <= OP_ADD;
      r_zero_acc <= 1'b1;
    end else if (w_accept) begin
      r_op <= w_op;
      if (w_end) begin
        r_cnt      <= '0;
        r_carry    <= 1'b0;
        r_zero_acc <= 1'b1;
      end else begin
        r_cnt      <= r_cnt + CNT_W'(1);
        r_carry    <= w_cout;
        r_zero_acc <= w_zero_all;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_last    <= 1'b0;
      out_carry   <= 1'b0;
      out_ovf     <= 1'b0;
      out_zero    <= 1'b0;
      out_len_err <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_sum     <= w_sum;
        out_last    <= w_end;
        out_carry   <= w_cout;
        out_ovf     <= w_c63 ^ w_cout;
        out_zero    <= w_zero_all;
        out_len_err <= w_end & ~in_last;
      end
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - directed self-checking bench for wide_add_seq
module tb_wide_add_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_op;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_last;
  logic        out_carry;
  logic        out_ovf;
  logic        out_zero;
  logic        out_len_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] ref_a;
  logic [255:0] ref_b;
  logic [256:0] ref_s;

  wide_add_seq #(.MAX_WORDS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_last    (out_last),
    .out_carry   (out_carry),
    .out_ovf     (out_ovf),
    .out_zero    (out_zero),
    .out_len_err (out_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic op, input logic last);
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},   64'(out_valid),   64'd0);
    chk({tag, "_sum"},     out_sum,          64'd0);
    chk({tag, "_last"},    64'(out_last),    64'd0);
    chk({tag, "_carry"},   64'(out_carry),   64'd0);
    chk({tag, "_ovf"},     64'(out_ovf),     64'd0);
    chk({tag, "_zero"},    64'(out_zero),    64'd0);
    chk({tag, "_lenerr"},  64'(out_len_err), 64'd0);
    chk({tag, "_inready"}, 64'(in_ready),    64'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2;
    chk_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // two-word add, carry crosses the word boundary
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    chk("add2_w0_valid", 64'(out_valid), 64'd1);
    chk("add2_w0_sum",   out_sum,        64'h0);
    chk("add2_w0_last",  64'(out_last),  64'd0);
    send(64'h0, 64'h0, 1'b0, 1'b1);
    chk("add2_w1_sum",   out_sum,        64'h1);
    chk("add2_w1_last",  64'(out_last),  64'd1);
    chk("add2_carry",    64'(out_carry), 64'd0);
    chk("add2_ovf",      64'(out_ovf),   64'd0);
    chk("add2_zero",     64'(out_zero),  64'd0);

    // single-word subtract to zero
    send(64'd5, 64'd5, 1'b1, 1'b1);
    chk("sub1_sum",    out_sum,          64'h0);
    chk("sub1_last",   64'(out_last),    64'd1);
    chk("sub1_carry",  64'(out_carry),   64'd1);
    chk("sub1_zero",   64'(out_zero),    64'd1);
    chk("sub1_ovf",    64'(out_ovf),     64'd0);

    // single-word signed overflow
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
    chk("ovf_sum",   out_sum,        64'h8000_0000_0000_0000);
    chk("ovf_ovf",   64'(out_ovf),   64'd1);
    chk("ovf_carry", 64'(out_carry), 64'd0);
    chk("ovf_zero",  64'(out_zero),  64'd0);

    // five words without in_last: truncation at word 4, word 5 starts fresh
    for (int i = 1; i <= 4; i++) begin
      send(64'(i), 64'h0, 1'b0, 1'b0);
      chk($sformatf("len_w%0d_sum", i),  out_sum,       64'(i));
      chk($sformatf("len_w%0d_last", i), 64'(out_last), (i == 4) ? 64'd1 : 64'd0);
    end
    chk("len_err",      64'(out_len_err), 64'd1);
    send(64'd3, 64'd1, 1'b1, 1'b1);
    chk("len_w5_sum",    out_sum,          64'd2);
    chk("len_w5_carry",  64'(out_carry),   64'd1);
    chk("len_w5_lenerr", 64'(out_len_err), 64'd0);

    // four-word add with a three-cycle downstream stall
    ref_a = {64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF};
    ref_b = {64'h8000_0000_0000_0000, 64'h0,
             64'hEDCB_A987_6543_2110, 64'h1};
    ref_s = {1'b0, ref_a} + {1'b0, ref_b};
    send(ref_a[63:0], ref_b[63:0], 1'b0, 1'b0);
    chk("stall_w0_sum", out_sum, ref_s[63:0]);
    out_ready = 1'b0;
    in_a      = ref_a[127:64];
    in_b      = ref_b[127:64];
    in_op     = 1'b0;
    in_last   = 1'b0;
    in_valid  = 1'b1;
    #1;
    chk("stall_inready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_inready", i), 64'(in_ready),  64'd0);
      chk($sformatf("stall%0d_valid", i),   64'(out_valid), 64'd1);
      chk($sformatf("stall%0d_sum", i),     out_sum,        ref_s[63:0]);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("stall_w1_sum", out_sum, ref_s[127:64]);
    send(ref_a[191:128], ref_b[191:128], 1'b0, 1'b0);
    chk("stall_w2_sum", out_sum, ref_s[191:128]);
    send(ref_a[255:192], ref_b[255:192], 1'b0, 1'b1);
    chk("stall_w3_sum",  out_sum,          ref_s[255:192]);
    chk("stall_last",    64'(out_last),    64'd1);
    chk("stall_carry",   64'(out_carry),   64'(ref_s[256]));
    chk("stall_ovf",     64'(out_ovf),
        64'((ref_a[255] == ref_b[255]) && (ref_s[255] != ref_a[255])));
    chk("stall_zero",    64'(out_zero),    64'(ref_s[255:0] == '0));
    chk("stall_lenerr",  64'(out_len_err), 64'd0);

    // reset in the middle of a four-word subtract
    send(64'h0, 64'h1, 1'b1, 1'b0);
    chk("mid_w0_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFF);
    send(64'h0, 64'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    send(64'd7, 64'd2, 1'b0, 1'b1);
    chk("post_rst_sum",   out_sum,        64'd9);
    chk("post_rst_last",  64'(out_last),  64'd1);
    chk("post_rst_carry", 64'(out_carry), 64'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 Parameter MAX_WORDS, default 4, SHALL set the maximum number of 64-bit words per operand (operand width up to 64*MAX_WORDS bits).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  an operand word pair is present.
REQ-005 in_ready  output  1  the block accepts the word pair this cycle.
REQ-006 in_a  input  64  word of operand A, least significant word first.
REQ-007 in_b  input  64  word of operand B, least significant word first.
REQ-008 in_op  input  1  0 = add, 1 = subtract (A-B); sampled on the first word only.
REQ-009 in_last  input  1  this is the most significant word of the operands.
REQ-010 out_valid  output  1  a result word is present.
REQ-011 out_ready  input  1  downstream accepts the result word.
REQ-012 out_sum  output  64  result word.
REQ-013 out_last  output  1  result word is the most significant word.
REQ-014 out_carry  output  1  final carry-out (add) or no-borrow (sub); valid only when out_last=1.
REQ-015 out_ovf  output  1  two's-complement overflow of the full-width result; valid only when out_last=1.
REQ-016 out_zero  output  1  every result word of this operation is zero; valid only when out_last=1.
REQ-017 out_len_err  output  1  operation was truncated at MAX_WORDS; valid only when out_last=1.

Function
REQ-018 Input handshake SHALL occur when in_valid and in_ready are both high; output handshake SHALL occur when out_valid and out_ready are both high.
REQ-019 in_ready SHALL equal (!out_valid | out_ready), giving full throughput of one word per cycle with no combinational path from in_valid to in_ready.
REQ-020 Latency SHALL be exactly one cycle: a word accepted in cycle n SHALL appear on the outputs in cycle n+1.
REQ-021 The FSM SHALL have states IDLE (awaiting first word) and RUN (mid-operation).
REQ-022 IDLE: on accept, latch in_op, use cin = in_op, go to RUN unless the word ends the operation.
REQ-023 RUN: on accept, use cin = stored carry, stay in RUN unless the word ends the operation, then return to IDLE.
REQ-024 A word SHALL end the operation if in_last=1 or it is word number MAX_WORDS (word counter = MAX_WORDS-1).
REQ-025 Each word SHALL compute sum = in_a + (op ? ~in_b : in_b) + cin in 64 bits; the 65th bit SHALL be stored as the next cin.
REQ-026 While a word is not accepted, the stored carry, op, word counter and zero accumulator SHALL hold.
REQ-027 out_ovf SHALL equal carry into bit 63 XOR carry out of bit 63 of the final word.
REQ-028 out_zero SHALL be the AND of (sum==0) over all words of the operation.
REQ-029 out_len_err SHALL be 1 only when the operation ended by reaching MAX_WORDS with in_last=0; out_last SHALL still be 1 on that word.
REQ-030 A single-word operation (in_last=1 in IDLE) SHALL complete entirely in IDLE.
REQ-031 Output registers SHALL hold stable while out_valid=1 and out_ready=0.
REQ-032 A new operation MAY be accepted in the cycle immediately after the previous last word is accepted; no bubble is required.

Reset
REQ-033 On rst_n low: state IDLE, word counter 0, stored carry 0, op 0, zero accumulator 1, out_valid 0, out_sum 0, out_last 0, out_carry 0, out_ovf 0, out_zero 0, out_len_err 0.
REQ-034 Reset asserted mid-operation SHALL discard the partial operation; the next accepted word SHALL be treated as a first word.

Structure
REQ-035 Package wadd_pkg SHALL hold WORD_W=64, the op encodings OP_ADD=0 and OP_SUB=1, the FSM state type, and the MAX_WORDS default.
REQ-036 The per-word adder SHALL be one instance of the existing 64-bit carry-lookahead adder cla64, with its cin and cout connected to the stored-carry logic.

Verification
REQ-037 Add, 2 words: A={0x0,0xFFFF_FFFF_FFFF_FFFF}, B={0x0,0x1} -> sums 0x0 then 0x1; out_carry=0; out_ovf=0; out_zero=0.
REQ-038 Sub, 1 word: A=5, B=5 -> sum 0; out_carry=1; out_zero=1; out_ovf=0.
REQ-039 Add, 1 word: A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> sum 0x8000_0000_0000_0000; out_ovf=1; out_carry=0.
REQ-040 Five words with no in_last, MAX_WORDS=4 -> 4th output has out_last=1 and out_len_err=1; 5th word starts a new operation.
REQ-041 Hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 and outputs stable; the 4-word result matches the 256-bit reference model.
REQ-042 Assert rst_n low after word 2 of 4 -> all outputs at reset values; the next word is processed with cin=in_op.
